// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, then releases the CPU from reset.
// Optional checksum verification of the loaded image: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned BOOT_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] prog_len,
  input  logic [9:0]  entry_pc,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [31:0] expected_sum,
`endif
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        halt,
  output logic        instr_we,
  output logic [31:0] instr_feed,
  output logic [9:0]  instr_write_address,
  output logic        cpu_rst,
  output logic [9:0]  init_pc,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, BOOT, RUN} state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [9:0]  pc_q, pc_d;
  logic        err_q, err_d;
  logic [3:0]  boot_q, boot_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [31:0] feed_q, feed_d;
  logic [9:0]  addr_q, addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] exp_q, exp_d;
`endif

  logic hs;
  logic last_word;

  assign hs        = s_valid && (state_q == LOAD);
  assign last_word = ({1'b0, cnt_q} == (len_q - 11'd1));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pc_d    = pc_q;
    err_d   = err_q;
    boot_d  = boot_q;
    done_d  = 1'b0;
    we_d    = hs;
    feed_d  = hs ? s_data : feed_q;
    addr_d  = hs ? cnt_q : addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    exp_d   = exp_q;
`endif

    if (halt) begin
      // Halt wins over everything, including a same-cycle start, and never flags an error.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((prog_len != 11'd0) && (prog_len <= 11'd1024)) begin
              len_d   = prog_len;
              pc_d    = entry_pc;
              err_d   = 1'b0;
              cnt_d   = '0;
              state_d = LOAD;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum_d   = '0;
              exp_d   = expected_sum;
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            cnt_d = cnt_q + 10'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d = sum_q + s_data;
            if (last_word) begin
              if (sum_d == exp_q) begin
                state_d = BOOT;
                boot_d  = '0;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
`else
            if (last_word) begin
              state_d = BOOT;
              boot_d  = '0;
            end
`endif
          end
        end
        BOOT: begin
          if (boot_q == 4'(BOOT_CYCLES - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            boot_d = boot_q + 4'd1;
          end
        end
        RUN:     ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      boot_q  <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      feed_q  <= '0;
      addr_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      boot_q  <= boot_d;
      done_q  <= done_d;
      we_q    <= we_d;
      feed_q  <= feed_d;
      addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      exp_q   <= exp_d;
`endif
    end
  end

  assign s_ready             = (state_q == LOAD);
  assign busy                = (state_q == LOAD) || (state_q == BOOT);
  assign cpu_rst             = (state_q != RUN);
  assign done                = done_q;
  assign err                 = err_q;
  assign init_pc             = pc_q;
  assign instr_we            = we_q;
  assign instr_feed          = feed_q;
  assign instr_write_address = addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (BOOT_CYCLES = 2).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] prog_len = '0;
  logic [9:0]  entry_pc = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        halt = 1'b0;
  logic        s_ready, instr_we, cpu_rst, busy, done, err;
  logic [31:0] instr_feed;
  logic [9:0]  instr_write_address, init_pc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] expected_sum = '0;
`endif

  int n_vec = 0;
  int n_err = 0;

  prog_loader #(.BOOT_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .prog_len            (prog_len),
    .entry_pc            (entry_pc),
`ifdef PROG_LOADER_CHECKSUM_EN
    .expected_sum        (expected_sum),
`endif
    .s_valid             (s_valid),
    .s_data              (s_data),
    .s_ready             (s_ready),
    .halt                (halt),
    .instr_we            (instr_we),
    .instr_feed          (instr_feed),
    .instr_write_address (instr_write_address),
    .cpu_rst             (cpu_rst),
    .init_pc             (init_pc),
    .busy                (busy),
    .done                (done),
    .err                 (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] len, input logic [9:0] pc);
    start = 1'b1; prog_len = len; entry_pc = pc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [9:0] exp_addr, input string tag);
    s_valid = 1'b1; s_data = w;
    tick();
    s_valid = 1'b0;
    check({tag, "_we"}, instr_we, 1);
    check({tag, "_addr"}, instr_write_address, exp_addr);
    check({tag, "_feed"}, instr_feed, w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_we"}, instr_we, 0);
    check({tag, "_addr"}, instr_write_address, 0);
    check({tag, "_feed"}, instr_feed, 0);
    check({tag, "_init_pc"}, init_pc, 0);
  endtask

  initial begin
    #3;
    check_reset_outputs("por");
    #10 rst = 1'b1;
    tick();

    // Three back-to-back words, entry 0x010
    do_start(11'd3, 10'h010);
    check("s1_s_ready", s_ready, 1);
    check("s1_busy", busy, 1);
    check("s1_init_pc", init_pc, 10'h010);
    check("s1_cpu_rst_load", cpu_rst, 1);
    s_valid = 1'b1; s_data = 32'hAAAA_0001;
    tick();
    check("s1_w0_we", instr_we, 1); check("s1_w0_addr", instr_write_address, 0);
    check("s1_w0_feed", instr_feed, 32'hAAAA_0001);
    s_data = 32'hBBBB_0002;
    tick();
    check("s1_w1_addr", instr_write_address, 1); check("s1_w1_feed", instr_feed, 32'hBBBB_0002);
    s_data = 32'hCCCC_0003;
    tick();
    s_valid = 1'b0;
    check("s1_w2_we", instr_we, 1); check("s1_w2_addr", instr_write_address, 2);
    check("s1_w2_feed", instr_feed, 32'hCCCC_0003);
    check("s1_boot1_s_ready", s_ready, 0);
    check("s1_boot1_busy", busy, 1);
    check("s1_boot1_cpu_rst", cpu_rst, 1);
    tick();
    check("s1_boot2_we", instr_we, 0);
    check("s1_boot2_cpu_rst", cpu_rst, 1);
    check("s1_boot2_done", done, 0);
    tick();
    check("s1_run_cpu_rst", cpu_rst, 0);
    check("s1_run_done", done, 1);
    check("s1_run_busy", busy, 0);
    check("s1_run_init_pc", init_pc, 10'h010);
    tick();
    check("s1_run_done_once", done, 0);
    check("s1_run_hold", cpu_rst, 0);

    // Stream and start are ignored while running
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    start = 1'b1; prog_len = 11'd2; entry_pc = 10'h3FF;
    tick();
    s_valid = 1'b0; start = 1'b0;
    check("run_sv_no_we", instr_we, 0);
    check("run_start_ignored", cpu_rst, 0);
    check("run_pc_kept", init_pc, 10'h010);

    // Halt from RUN
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_run_cpu_rst", cpu_rst, 1);
    check("halt_run_err", err, 0);
    check("halt_run_busy", busy, 0);

    // Gapped stream: two idle cycles between words
    do_start(11'd3, 10'h123);
    for (int i = 0; i < 3; i++) begin
      push_word(32'h1000_0000 + i, 10'(i), $sformatf("gap_w%0d", i));
      for (int g = 0; g < 2; g++) begin
        tick();
        check($sformatf("gap_w%0d_idle%0d_we", i, g), instr_we, 0);
      end
    end
    check("gap_run", cpu_rst, 0);
    check("gap_init_pc", init_pc, 10'h123);
    halt = 1'b1; tick(); halt = 1'b0;

    // Illegal lengths
    do_start(11'd0, 10'h055);
    check("len0_err", err, 1);
    check("len0_s_ready", s_ready, 0);
    check("len0_busy", busy, 0);
    do_start(11'd1025, 10'h055);
    check("len1025_err", err, 1);
    check("len1025_s_ready", s_ready, 0);
    check("len1025_pc_kept", init_pc, 10'h123);

    // Halt beats a same-cycle start
    start = 1'b1; halt = 1'b1; prog_len = 11'd4; entry_pc = 10'h077;
    tick();
    start = 1'b0; halt = 1'b0;
    check("halt_start_s_ready", s_ready, 0);
    check("halt_start_err", err, 1);

    // Max length accepted clears err; abandon with halt
    do_start(11'd1024, 10'h200);
    check("len1024_err_clr", err, 0);
    check("len1024_s_ready", s_ready, 1);
    halt = 1'b1; tick(); halt = 1'b0;

    // Halt after first word of four, then reload from address 0
    do_start(11'd4, 10'h040);
    push_word(32'h0000_00A1, 10'd0, "abort_w0");
    halt = 1'b1; tick(); halt = 1'b0;
    check("abort_s_ready", s_ready, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_err", err, 0);
    check("abort_busy", busy, 0);
    do_start(11'd1, 10'h041);
    push_word(32'h0000_00B2, 10'd0, "reload_w0");
    check("reload_boot", busy, 1);
    tick();
    tick();
    check("reload_done", done, 1);
    check("reload_run", cpu_rst, 0);
    check("reload_pc", init_pc, 10'h041);
    halt = 1'b1; tick(); halt = 1'b0;

    // Asynchronous reset mid-load
    do_start(11'd4, 10'h155);
    push_word(32'h5555_AAAA, 10'd0, "arst_w0");
    s_valid = 1'b1; s_data = 32'h1234_5678;
    #2 rst = 1'b0;
    #1;
    s_valid = 1'b0;
    check_reset_outputs("arst");
    #10 rst = 1'b1;
    tick();
    check("arst_post_idle", s_ready, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum matches: 1+2+3 == 6
    expected_sum = 32'd6;
    do_start(11'd3, 10'h010);
    for (int i = 0; i < 3; i++) push_word(32'(i + 1), 10'(i), $sformatf("cs_ok_w%0d", i));
    check("cs_ok_boot", busy, 1);
    check("cs_ok_err", err, 0);
    tick(); tick();
    check("cs_ok_run", cpu_rst, 0);
    check("cs_ok_done", done, 1);
    halt = 1'b1; tick(); halt = 1'b0;
    // Checksum mismatch: expected 7
    expected_sum = 32'd7;
    do_start(11'd3, 10'h010);
    for (int i = 0; i < 3; i++) push_word(32'(i + 1), 10'(i), $sformatf("cs_bad_w%0d", i));
    check("cs_bad_err", err, 1);
    check("cs_bad_busy", busy, 0);
    check("cs_bad_cpu_rst", cpu_rst, 1);
    check("cs_bad_s_ready", s_ready, 0);
    tick(); tick();
    check("cs_bad_no_run", cpu_rst, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
